matrix_scan_driver: RTL and testbench
=====================================

// Module: matrix_scan_driver
// PURPOSE
//  Downstream consumer of the AXI4-Lite matrix register block. Takes the 4x32-bit register frame
//  (128 bits) and time-multiplexes it onto an 8-row x 16-column LED matrix, one row at a time.
//  Double-buffered: new frames are held as pending and become active only at a frame boundary.
//  Inter-row blanking suppresses ghosting.
// PARAMETERS
//  ROWS            8     matrix rows; ROWS*COLS must equal FRAME_W
//  COLS            16    matrix columns
//  FRAME_W         128   frame width in bits (4 x 32-bit registers)
//  ROW_CYCLES      1000  ACLK cycles per row slot (>= BLANK_CYCLES+1)
//  BLANK_CYCLES    50    cycles at the start of each slot with all rows/cols inactive (>= 1)
//  ROW_ACTIVE_LOW  1     1: row_o driven 0 for the active row
//  COL_ACTIVE_LOW  0     1: col_o bit driven 0 for a lit pixel
// PORTS
//  ACLK           in   1        clock; single clock domain
//  ARESET         in   1        reset, asynchronous, active-high
//  enable_i       in   1        0: blank outputs and restart scan at row 0
//  frame_i        in   FRAME_W  register frame; {reg3,reg2,reg1,reg0}
//  frame_valid_i  in   1        1-cycle pulse: frame_i holds a new frame (any AXI reg write)
//  row_o          out  ROWS     row select, one-hot at the active level during SHOW
//  col_o          out  COLS     column data for the current row
//  frame_start_o  out  1        1-cycle pulse in each LOAD cycle
//  frame_ack_o    out  1        1-cycle pulse when a pending frame is promoted to active
//  overrun_o      out  1        1-cycle pulse when frame_valid_i overwrites a frame still pending
// BEHAVIOUR
//  - Reset (async): state LOAD, row_idx 0, slot counter 0, active/pending buffers 0, pend_flag 0.
//    row_o and col_o at the inactive level. All pulse outputs 0. All outputs registered.
//  - FSM states: LOAD -> BLANK -> SHOW -> (BLANK for row+1 | LOAD after row ROWS-1).
//    - LOAD is 1 cycle. If pend_flag is set: active <= pending, clear pend_flag, pulse frame_ack_o.
//      frame_start_o pulses. Next state is BLANK with row_idx 0.
//    - BLANK runs BLANK_CYCLES cycles with row_o and col_o inactive.
//    - SHOW runs ROW_CYCLES-BLANK_CYCLES cycles. row_o[row_idx] is active.
//      col_o = active[row_idx*COLS +: COLS] with bit c driving column c, polarity applied.
//  - Frame period = 1 + ROWS*ROW_CYCLES cycles.
//  - Mapping: reg0[15:0] is row 0, reg0[31:16] is row 1, ..., reg3[31:16] is row 7.
//  - frame_valid_i in any state except LOAD: pending <= frame_i, pend_flag <= 1.
//    If pend_flag was already 1, overrun_o pulses and the newer frame wins.
//  - frame_valid_i in the LOAD cycle: frame_i loads active directly and pend_flag is cleared.
//    frame_ack_o pulses. Any older pending frame is discarded without an overrun pulse.
//  - enable_i low: next cycle the FSM enters LOAD-hold and stays there.
//    Outputs are inactive; frame_start_o does not pulse while held. Pending capture continues.
//    On enable_i rising, LOAD executes once (with its promotion rule), then scanning starts at row 0.
//  - Counters wrap only via FSM transitions; slot counter is $clog2(ROW_CYCLES) bits.
//    No implicit overflow.
//  - ARESET mid-frame: immediate return to reset values. The pending frame is lost.
// STRUCTURE
//  - matrix_pkg: state enum scan_state_t {LOAD, BLANK, SHOW}, default geometry localparams.
//    Also holds the polarity helper function.
//  - Sub-module matrix_row_timer: slot counter.
//    Outputs blank_done and slot_done strobes, with a restart input.
//  - Top holds the FSM, row_idx, double buffer and output registers.
// TESTING  (bench params: ROW_CYCLES=10, BLANK_CYCLES=2, defaults otherwise)
//  1. Reset, then hold ARESET=1 for 5 cycles.
//     -> row_o=8'hFF, col_o=16'h0000, all pulses 0; release -> frame_start_o at first cycle.
//  2. Pulse frame_i={32'h4,32'h3,32'h2,32'h1} mid-frame.
//     -> no change until next LOAD; there frame_ack_o=1.
//     -> Row 0 SHOW col_o=16'h0001, row 2 col_o=16'h0002, rows 1,3 16'h0000.
//  3. During a row slot:
//     -> 2 cycles row_o=8'hFF, then 8 cycles row_o=~(8'h1<<r).
//     -> frame_start_o spacing = 81 cycles.
//  4. Two frame_valid_i pulses in one frame (A then B).
//     -> one overrun_o pulse; B displayed after LOAD, A never displayed.
//  5. frame_valid_i coincident with LOAD.
//     -> that frame shown from row 0 of the same frame; frame_ack_o in the same LOAD cycle.
//  6. enable_i=0 during row 5 SHOW.
//     -> outputs inactive next cycle, no frame_start_o while low.
//     -> re-enable -> frame_start_o, then row 0 scan.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: scan state type, default matrix geometry and the
// output polarity helper shared by the LED matrix scan driver.
package matrix_pkg;

  typedef enum logic [1:0] {
    LOAD,
    BLANK,
    SHOW
  } scan_state_t;

  localparam int ROWS_D         = 8;
  localparam int COLS_D         = 16;
  localparam int FRAME_W_D      = 128;
  localparam int ROW_CYCLES_D   = 1000;
  localparam int BLANK_CYCLES_D = 50;

  // Maps a logical "on" bit to the pin level for the given polarity.
  function automatic logic pol(
    input logic v,
    input logic act_low
  );
    return v ^ act_low;
  endfunction

endpackage

// File: rtl/matrix_row_timer.sv
// matrix_row_timer: per-row slot counter for the scan driver.
// Ports: ACLK/ARESET, restart (force count to 0), blank_done and
// slot_done strobes (last blank cycle / last cycle of the slot).
module matrix_row_timer #(
  parameter int ROW_CYCLES   = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic restart,
  output logic blank_done,
  output logic slot_done
);

  localparam int CW = $clog2(ROW_CYCLES);

  logic [CW-1:0] cnt;

  assign blank_done = (cnt == CW'(BLANK_CYCLES - 1));
  assign slot_done  = (cnt == CW'(ROW_CYCLES - 1));

  // Wraps at the slot end, so the count never runs past ROW_CYCLES-1.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt <= '0;
    end else if (restart || slot_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_scan_driver.sv
// matrix_scan_driver: double-buffered 128-bit frame scanned one row
// at a time onto an 8x16 LED matrix with inter-row blanking.
// Ports: ACLK/ARESET, enable_i, frame_i/frame_valid_i (new frame),
// row_o/col_o (matrix pins), frame_start_o, frame_ack_o, overrun_o.
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int ROWS           = ROWS_D,
  parameter int COLS           = COLS_D,
  parameter int FRAME_W        = FRAME_W_D,
  parameter int ROW_CYCLES     = ROW_CYCLES_D,
  parameter int BLANK_CYCLES   = BLANK_CYCLES_D,
  parameter bit ROW_ACTIVE_LOW = 1'b1,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               enable_i,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic               frame_valid_i,
  output logic [ROWS-1:0]    row_o,
  output logic [COLS-1:0]    col_o,
  output logic               frame_start_o,
  output logic               frame_ack_o,
  output logic               overrun_o
);

  localparam int RW = $clog2(ROWS);

  scan_state_t        state;
  scan_state_t        nxt_state;
  logic [RW-1:0]      row_idx;
  logic [FRAME_W-1:0] active;
  logic [FRAME_W-1:0] pending;
  logic               pend_flag;
  logic               blank_done;
  logic               slot_done;
  logic               load_exec;
  logic               last_row;

  logic [ROWS-1:0]    row_on;
  logic [COLS-1:0]    col_on;
  logic [ROWS-1:0]    row_d;
  logic [COLS-1:0]    col_d;
  logic               fs_d;
  logic               ack_d;
  logic               ovr_d;

  // LOAD with enable low is the hold state: nothing is promoted.
  assign load_exec = (state == LOAD) && enable_i;
  assign last_row  = (row_idx == RW'(ROWS - 1));

  matrix_row_timer #(
    .ROW_CYCLES  (ROW_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .restart   ((state == LOAD) || !enable_i),
    .blank_done(blank_done),
    .slot_done (slot_done)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= LOAD;
    end else begin
      state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = state;
    unique case (state)
      LOAD: begin
        if (enable_i) nxt_state = BLANK;
      end
      BLANK: begin
        if (!enable_i) nxt_state = LOAD;
        else if (blank_done) nxt_state = SHOW;
      end
      SHOW: begin
        if (!enable_i) nxt_state = LOAD;
        else if (slot_done) nxt_state = last_row ? LOAD : BLANK;
      end
      default: nxt_state = LOAD;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      row_idx   <= '0;
      active    <= '0;
      pending   <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (state == LOAD) begin
        row_idx <= '0;
      end else if (state == SHOW && enable_i && slot_done) begin
        row_idx <= last_row ? '0 : row_idx + 1'b1;
      end
      // A frame arriving in LOAD bypasses the pending buffer.
      if (load_exec) begin
        if (frame_valid_i) begin
          active <= frame_i;
        end else if (pend_flag) begin
          active <= pending;
        end
        pend_flag <= 1'b0;
      end else if (frame_valid_i) begin
        pending   <= frame_i;
        pend_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    row_on = '0;
    col_on = '0;
    if (state == SHOW && enable_i) begin
      row_on = ROWS'(1) << row_idx;
      col_on = active[int'(row_idx) * COLS +: COLS];
    end
    for (int i = 0; i < ROWS; i++) begin
      row_d[i] = pol(row_on[i], ROW_ACTIVE_LOW);
    end
    for (int i = 0; i < COLS; i++) begin
      col_d[i] = pol(col_on[i], COL_ACTIVE_LOW);
    end
    fs_d  = load_exec;
    ack_d = load_exec && (frame_valid_i || pend_flag);
    ovr_d = frame_valid_i && !load_exec && pend_flag;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      row_o         <= {ROWS{ROW_ACTIVE_LOW}};
      col_o         <= {COLS{COL_ACTIVE_LOW}};
      frame_start_o <= 1'b0;
      frame_ack_o   <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      row_o         <= row_d;
      col_o         <= col_d;
      frame_start_o <= fs_d;
      frame_ack_o   <= ack_d;
      overrun_o     <= ovr_d;
    end
  end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb_matrix_scan_driver: directed bench for matrix_scan_driver with
// 10-cycle row slots and 2 blank cycles (81-cycle frame).
module tb_matrix_scan_driver;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic         enable_i;
  logic [127:0] frame_i;
  logic         frame_valid_i;
  logic [7:0]   row_o;
  logic [15:0]  col_o;
  logic         frame_start_o;
  logic         frame_ack_o;
  logic         overrun_o;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  matrix_scan_driver #(
    .ROW_CYCLES  (10),
    .BLANK_CYCLES(2)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .enable_i     (enable_i),
    .frame_i      (frame_i),
    .frame_valid_i(frame_valid_i),
    .row_o        (row_o),
    .col_o        (col_o),
    .frame_start_o(frame_start_o),
    .frame_ack_o  (frame_ack_o),
    .overrun_o    (overrun_o)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (frame_start_o !== 1'b1 && n < 200);
    checks++;
    if (frame_start_o !== 1'b1) begin
      errors++;
      $display("FAIL wait_fs: frame_start_o=%b after %0d cycles, want 1",
               frame_start_o, n);
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    enable_i = 1'b1;
    frame_valid_i = 1'b0;
    frame_i = '0;
    step(5);
    checks++;
    if ({row_o, col_o} !== {8'hFF, 16'h0000}) begin
      errors++;
      $display("FAIL reset_pins: row=%h col=%h want ff 0000", row_o, col_o);
    end
    checks++;
    if ({frame_start_o, frame_ack_o, overrun_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: %b want 000",
               {frame_start_o, frame_ack_o, overrun_o});
    end
    ARESET = 1'b0;
    step();
    checks++;
    if ({frame_start_o, frame_ack_o} !== 2'b10) begin
      errors++;
      $display("FAIL first_load: fs,ack=%b want 10",
               {frame_start_o, frame_ack_o});
    end
  endtask

  task automatic test_frame_mapping();
    int n;
    wait_fs(n);
    step(5);
    frame_i = {32'h4, 32'h3, 32'h2, 32'h1};
    frame_valid_i = 1'b1;
    step();
    frame_valid_i = 1'b0;
    checks++;
    if ({frame_ack_o, overrun_o} !== 2'b00) begin
      errors++;
      $display("FAIL map_no_ack: ack,ovr=%b want 00",
               {frame_ack_o, overrun_o});
    end
    step(17);
    checks++;
    if ({row_o, col_o} !== {8'hFB, 16'h0000}) begin
      errors++;
      $display("FAIL map_still_old: row=%h col=%h want fb 0000", row_o, col_o);
    end
    wait_fs(n);
    checks++;
    if (n !== 58 || frame_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL map_ack: n=%0d ack=%b want 58 1", n, frame_ack_o);
    end
    step(3);
    checks++;
    if ({row_o, col_o} !== {8'hFE, 16'h0001}) begin
      errors++;
      $display("FAIL map_row0: row=%h col=%h want fe 0001", row_o, col_o);
    end
    step(10);
    checks++;
    if ({row_o, col_o} !== {8'hFD, 16'h0000}) begin
      errors++;
      $display("FAIL map_row1: row=%h col=%h want fd 0000", row_o, col_o);
    end
    step(10);
    checks++;
    if ({row_o, col_o} !== {8'hFB, 16'h0002}) begin
      errors++;
      $display("FAIL map_row2: row=%h col=%h want fb 0002", row_o, col_o);
    end
    step(10);
    checks++;
    if ({row_o, col_o} !== {8'hF7, 16'h0000}) begin
      errors++;
      $display("FAIL map_row3: row=%h col=%h want f7 0000", row_o, col_o);
    end
  endtask

  task automatic test_row_timing();
    int n;
    logic [127:0] f;
    logic [7:0] er;
    logic [15:0] ec;
    f = {32'h4, 32'h3, 32'h2, 32'h1};
    wait_fs(n);
    for (int k = 1; k <= 80; k++) begin
      int r;
      int p;
      step();
      r = (k - 1) / 10;
      p = (k - 1) % 10;
      er = 8'h01 << r;
      er = ~er;
      ec = f[r*16 +: 16];
      if (p < 2) begin
        er = 8'hFF;
        ec = 16'h0000;
      end
      checks++;
      if ({frame_start_o, row_o, col_o} !== {1'b0, er, ec}) begin
        errors++;
        $display("FAIL slot k=%0d: fs=%b row=%h col=%h want 0 %h %h",
                 k, frame_start_o, row_o, col_o, er, ec);
      end
    end
    wait_fs(n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL fs_spacing: %0d want 81", 80 + n);
    end
  endtask

  task automatic test_overrun();
    int n;
    int ovr;
    logic [127:0] a;
    logic [127:0] b;
    a = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
    b = {32'h0F0FF0F0, 32'h80000001, 32'h00FFFF00, 32'h12345555};
    ovr = 0;
    wait_fs(n);
    step(5);
    frame_i = a;
    frame_valid_i = 1'b1;
    step();
    frame_valid_i = 1'b0;
    ovr += int'(overrun_o);
    for (int i = 0; i < 10; i++) begin
      step();
      ovr += int'(overrun_o);
    end
    frame_i = b;
    frame_valid_i = 1'b1;
    step();
    frame_valid_i = 1'b0;
    ovr += int'(overrun_o);
    n = 0;
    while (frame_start_o !== 1'b1 && n < 200) begin
      step();
      ovr += int'(overrun_o);
      n++;
    end
    checks++;
    if (ovr !== 1) begin
      errors++;
      $display("FAIL ovr_count: %0d want 1", ovr);
    end
    checks++;
    if ({frame_start_o, frame_ack_o} !== 2'b11) begin
      errors++;
      $display("FAIL ovr_ack: fs,ack=%b want 11", {frame_start_o, frame_ack_o});
    end
    step(3);
    checks++;
    if (col_o !== 16'h5555) begin
      errors++;
      $display("FAIL ovr_row0: col=%h want 5555", col_o);
    end
    step(10);
    checks++;
    if (col_o !== 16'h1234) begin
      errors++;
      $display("FAIL ovr_row1: col=%h want 1234", col_o);
    end
  endtask

  task automatic test_load_coincident();
    int n;
    wait_fs(n);
    step(10);
    frame_i = {96'h0, 32'h0000DDDD};
    frame_valid_i = 1'b1;
    step();
    frame_valid_i = 1'b0;
    step(69);
    frame_i = {96'h0, 32'hC0DEBEEF};
    frame_valid_i = 1'b1;
    step();
    frame_valid_i = 1'b0;
    checks++;
    if ({frame_start_o, frame_ack_o, overrun_o} !== 3'b110) begin
      errors++;
      $display("FAIL coinc_load: fs,ack,ovr=%b want 110",
               {frame_start_o, frame_ack_o, overrun_o});
    end
    step(3);
    checks++;
    if ({row_o, col_o} !== {8'hFE, 16'hBEEF}) begin
      errors++;
      $display("FAIL coinc_row0: row=%h col=%h want fe beef", row_o, col_o);
    end
    step(10);
    checks++;
    if (col_o !== 16'hC0DE) begin
      errors++;
      $display("FAIL coinc_row1: col=%h want c0de", col_o);
    end
    wait_fs(n);
    checks++;
    if (frame_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL coinc_no_reack: ack=%b want 0", frame_ack_o);
    end
    step(3);
    checks++;
    if (col_o !== 16'hBEEF) begin
      errors++;
      $display("FAIL coinc_kept: col=%h want beef", col_o);
    end
  endtask

  task automatic test_enable_hold();
    int n;
    wait_fs(n);
    step(55);
    checks++;
    if (row_o !== 8'hDF) begin
      errors++;
      $display("FAIL hold_row5: row=%h want df", row_o);
    end
    enable_i = 1'b0;
    step();
    checks++;
    if ({row_o, col_o} !== {8'hFF, 16'h0000}) begin
      errors++;
      $display("FAIL hold_blank: row=%h col=%h want ff 0000", row_o, col_o);
    end
    for (int i = 0; i < 20; i++) begin
      frame_i = {96'h0, 32'h0000F00D};
      frame_valid_i = (i == 5);
      step();
      checks++;
      if ({frame_start_o, frame_ack_o, row_o, col_o} !==
          {2'b00, 8'hFF, 16'h0000}) begin
        errors++;
        $display("FAIL hold_%0d: fs=%b ack=%b row=%h col=%h want 0 0 ff 0000",
                 i, frame_start_o, frame_ack_o, row_o, col_o);
      end
    end
    frame_valid_i = 1'b0;
    enable_i = 1'b1;
    step();
    checks++;
    if ({frame_start_o, frame_ack_o} !== 2'b11) begin
      errors++;
      $display("FAIL reen_load: fs,ack=%b want 11", {frame_start_o, frame_ack_o});
    end
    step(2);
    checks++;
    if (row_o !== 8'hFF) begin
      errors++;
      $display("FAIL reen_blank: row=%h want ff", row_o);
    end
    step();
    checks++;
    if ({row_o, col_o} !== {8'hFE, 16'hF00D}) begin
      errors++;
      $display("FAIL reen_row0: row=%h col=%h want fe f00d", row_o, col_o);
    end
  endtask

  task automatic test_async_reset();
    int n;
    wait_fs(n);
    step(5);
    frame_i = {96'h0, 32'h00007777};
    frame_valid_i = 1'b1;
    step();
    frame_valid_i = 1'b0;
    step(20);
    ARESET = 1'b1;
    #1;
    checks++;
    if ({row_o, col_o, frame_start_o} !== {8'hFF, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL async_rst: row=%h col=%h fs=%b want ff 0000 0",
               row_o, col_o, frame_start_o);
    end
    step(3);
    ARESET = 1'b0;
    step();
    checks++;
    if ({frame_start_o, frame_ack_o} !== 2'b10) begin
      errors++;
      $display("FAIL rst_pend_lost: fs,ack=%b want 10",
               {frame_start_o, frame_ack_o});
    end
    step(3);
    checks++;
    if ({row_o, col_o} !== {8'hFE, 16'h0000}) begin
      errors++;
      $display("FAIL rst_active_clr: row=%h col=%h want fe 0000", row_o, col_o);
    end
  endtask

  initial begin
    test_reset();
    test_frame_mapping();
    test_row_timing();
    test_overrun();
    test_load_coincident();
    test_enable_hold();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
